// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states and byte/half/word access
//
// Purpose:
//   Responder side of the pipeline data-memory interface. Accepts one load or
//   store at a time, holds the requester on Stall for LATENCY cycles, then
//   pulses Ack for one cycle. Loads return a zero- or sign-extended value on
//   DataOut during Ack; stores commit at the clock edge that ends the Ack cycle.
//   Little-endian byte lanes; Digit 00=byte, 01=half, 10/11=word.
//
// Optional feature macro: MISALIGN_TRAP_EN
//   Defined   : misaligned half/word accesses complete with Fault=1, DataOut=0
//               and no array write.
//   Undefined : Fault is tied 0 and misaligned addresses are truncated to the
//               access alignment.
//
// Ports:
//   CLK      in   1   clock, rising edge
//   Reset    in   1   synchronous active-high reset
//   Req      in   1   request valid, held until Ack
//   DataWr   in   1   1 = store, 0 = load
//   Digit    in   2   access size
//   Sign     in   1   load sign-extension select
//   DAddr    in   32  byte address
//   DataIn   in   32  right-aligned store data
//   DataOut  out  32  load result during Ack, otherwise 0
//   Ack      out  1   one-cycle completion pulse
//   Stall    out  1   Req & ~Ack
//   Fault    out  1   misaligned-access flag, coincident with Ack

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Req,
  input  logic        DataWr,
  input  logic [1:0]  Digit,
  input  logic        Sign,
  input  logic [31:0] DAddr,
  input  logic [31:0] DataIn,
  output logic [31:0] DataOut,
  output logic        Ack,
  output logic        Stall,
  output logic        Fault
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [3:0]    count;
  logic          cap_wr;
  logic [1:0]    cap_digit;
  logic          cap_sign;
  logic [AW+1:0] cap_addr;
  logic [31:0]   cap_data;

  logic [31:0]   mem [DEPTH_WORDS];

  logic [AW-1:0] word_idx;
  logic          misalign;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_val;

  // Address bits above the array index wrap around and are deliberately dropped.
  logic          unused_addr_bits;
  assign unused_addr_bits = &{1'b0, DAddr[31:AW+2]};

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (Req) begin
          state_nxt = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      // The counter was loaded with LATENCY-1; leaving at 1 puts Ack in the
      // cycle after edge N+LATENCY-1.
      S_WAIT: begin
        if (count == 4'd1) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request capture and wait counter. Captured fields govern the whole
  // transaction; the inputs are not looked at again after accept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (Reset) begin
      count     <= 4'd0;
      cap_wr    <= 1'b0;
      cap_digit <= 2'b00;
      cap_sign  <= 1'b0;
      cap_addr  <= '0;
      cap_data  <= 32'd0;
    end else if (state == S_IDLE && Req) begin
      count     <= CNT_INIT;
      cap_wr    <= DataWr;
      cap_digit <= Digit;
      cap_sign  <= Sign;
      cap_addr  <= DAddr[AW+1:0];
      cap_data  <= DataIn;
    end else if (state == S_WAIT) begin
      count <= count - 4'd1;
    end
  end

  assign word_idx = cap_addr[AW+1:2];

  // ---------------------------------------------------------------------------
  // Misalignment detection
  // ---------------------------------------------------------------------------
`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    case (cap_digit)
      2'b00:   misalign = 1'b0;
      2'b01:   misalign = cap_addr[0];
      default: misalign = |cap_addr[1:0];
    endcase
  end
`else
  assign misalign = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Store lane steering: replicate the right-aligned data across all lanes and
  // let the byte enables pick the addressed ones.
  // ---------------------------------------------------------------------------
  always_comb begin
    be    = 4'b0000;
    wdata = cap_data;
    case (cap_digit)
      2'b00: begin
        be    = 4'b0001 << cap_addr[1:0];
        wdata = {4{cap_data[7:0]}};
      end
      2'b01: begin
        be    = cap_addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{cap_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = cap_data;
      end
    endcase
  end

  // The write lands on the edge that ends RESP; a Reset on that same edge
  // discards it.
  always_ff @(posedge CLK) begin
    if (!Reset && state == S_RESP && cap_wr && !misalign) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Load path: lane select and extension
  // ---------------------------------------------------------------------------
  assign rword = mem[word_idx];

  always_comb begin
    rbyte = rword[7:0];
    case (cap_addr[1:0])
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
  end

  assign rhalf = cap_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_val = rword;
    case (cap_digit)
      2'b00:   load_val = {{24{cap_sign & rbyte[7]}}, rbyte};
      2'b01:   load_val = {{16{cap_sign & rhalf[15]}}, rhalf};
      default: load_val = rword;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    Ack     = 1'b0;
    Fault   = 1'b0;
    DataOut = 32'd0;
    if (state == S_RESP) begin
      Ack   = 1'b1;
      Fault = misalign;
      if (!cap_wr && !misalign) begin
        DataOut = load_val;
      end
    end
  end

  assign Stall = Req & ~Ack;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder

module tb_dmem_responder;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset;
  logic        Req;
  logic        DataWr;
  logic [1:0]  Digit;
  logic        Sign;
  logic [31:0] DAddr;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        Ack;
  logic        Stall;
  logic        Fault;

  int checks = 0;
  int passes = 0;

  always #5 CLK = ~CLK;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .LATENCY     (2)
  ) dut (
    .CLK     (CLK),
    .Reset   (Reset),
    .Req     (Req),
    .DataWr  (DataWr),
    .Digit   (Digit),
    .Sign    (Sign),
    .DAddr   (DAddr),
    .DataIn  (DataIn),
    .DataOut (DataOut),
    .Ack     (Ack),
    .Stall   (Stall),
    .Fault   (Fault)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // One full transaction. Inputs are scrambled after accept to confirm the
  // captured copy is what gets used; Req is dropped during the Ack cycle.
  task automatic txn(input string tag, input logic wr, input logic [1:0] dg, input logic sg,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_dout, input logic exp_fault);
    int lat;
    @(negedge CLK);
    Req    = 1'b1;
    DataWr = wr;
    Digit  = dg;
    Sign   = sg;
    DAddr  = addr;
    DataIn = din;
    lat    = 0;
    while (Ack !== 1'b1 && lat < 20) begin
      #1;
      check({tag, " stall"}, 32'(Stall), 32'd1);
      @(negedge CLK);
      lat++;
      if (lat == 1) begin
        DataWr = ~wr;
        Digit  = ~dg;
        Sign   = ~sg;
        DAddr  = ~addr;
        DataIn = ~din;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    check({tag, " dout"}, DataOut, exp_dout);
    check({tag, " fault"}, 32'(Fault), 32'(exp_fault));
    check({tag, " stall at ack"}, 32'(Stall), 32'd0);
    Req = 1'b0;
    #1;
    check({tag, " ack after drop"}, 32'(Ack), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset  = 1'b1;
    Req    = 1'b0;
    DataWr = 1'b0;
    Digit  = 2'b00;
    Sign   = 1'b0;
    DAddr  = 32'd0;
    DataIn = 32'd0;
    repeat (2) @(negedge CLK);
    check("reset ack", 32'(Ack), 32'd0);
    check("reset dout", DataOut, 32'd0);
    check("reset fault", 32'(Fault), 32'd0);
    check("reset stall", 32'(Stall), 32'd0);

    // Reset and Req together: Stall follows Req, request is not captured.
    Req = 1'b1;
    DataWr = 1'b0;
    Digit = 2'b10;
    #1;
    check("reset+req stall", 32'(Stall), 32'd1);
    @(negedge CLK);
    Reset = 1'b0;
    Req   = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("reset wins no ack", 32'(Ack), 32'd0);
    end

    // Word store/load
    txn("st w 10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0);
    txn("ld w 10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);
    txn("ld d11 10", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

    // Byte merge and sign extension
    txn("st w 20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0);
    txn("st b 22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h55AA1180, 32'h0, 1'b0);
    txn("ld w 20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0);
    txn("ld bs 22", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'hFFFFFF80, 1'b0);
    txn("ld bz 22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'h00000080, 1'b0);
    txn("ld bs 23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 32'h00000000, 1'b0);

    // Half ops
    txn("st w 30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h5555AAAA, 32'h0, 1'b0);
    txn("st h 32", 1'b1, 2'b01, 1'b0, 32'h32, 32'hFFFF8001, 32'h0, 1'b0);
    txn("ld hs 32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 32'hFFFF8001, 1'b0);
    txn("ld hz 32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 32'h00008001, 1'b0);
    txn("ld hs 30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 32'hFFFFAAAA, 1'b0);
    txn("ld w 30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h8001AAAA, 1'b0);

    // Wrap-around: 0x400 maps to word 0 of a 256-word array
    txn("st w 400", 1'b1, 2'b10, 1'b0, 32'h400, 32'h12345678, 32'h0, 1'b0);
    txn("ld w 000", 1'b0, 2'b10, 1'b0, 32'h000, 32'h0, 32'h12345678, 1'b0);

    // Reset during WAIT discards the store
    txn("st w 40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, 32'h0, 1'b0);
    @(negedge CLK);
    Req    = 1'b1;
    DataWr = 1'b1;
    Digit  = 2'b10;
    Sign   = 1'b0;
    DAddr  = 32'h40;
    DataIn = 32'hAAAAAAAA;
    @(negedge CLK);
    Reset = 1'b1;
    Req   = 1'b0;
    @(negedge CLK);
    check("mid reset ack", 32'(Ack), 32'd0);
    check("mid reset dout", DataOut, 32'd0);
    check("mid reset fault", 32'(Fault), 32'd0);
    check("mid reset stall", 32'(Stall), 32'd0);
    Reset = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("mid reset no ack", 32'(Ack), 32'd0);
    end
    txn("ld w 40 kept", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h01020304, 1'b0);

    // Misaligned word store and load
    txn("st w 41 mis", 1'b1, 2'b10, 1'b0, 32'h41, 32'hCAFEBABE, 32'h0, TRAP);
    txn("ld w 40 after mis", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,
        TRAP ? 32'h01020304 : 32'hCAFEBABE, 1'b0);
    txn("ld w 43 mis", 1'b0, 2'b10, 1'b0, 32'h43, 32'h0,
        TRAP ? 32'h00000000 : (TRAP ? 32'h01020304 : 32'hCAFEBABE), TRAP);

    @(negedge CLK);
    check("idle ack", 32'(Ack), 32'd0);
    check("idle dout", DataOut, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
